// File: rtl/de270_timer_driver.sv
// Avalon-MM initiator for the DE270 interval timer: programs the period, runs the
// timer continuously, services each timeout IRQ, takes snapshots and stops on command.
module de270_timer_driver #(
    parameter int MIN_PERIOD = 16,
    parameter int TICK_W     = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [31:0]       cfg_period,
    input  logic              cfg_start,
    input  logic              cfg_stop,
    input  logic              snap_req,
    output logic              busy,
    output logic              running,
    output logic              tick,
    output logic [TICK_W-1:0] tick_count,
    output logic [31:0]       snap_value,
    output logic              snap_valid,
    output logic [2:0]        avm_address,
    output logic              avm_chipselect,
    output logic              avm_write_n,
    output logic [15:0]       avm_writedata,
    input  logic [15:0]       avm_readdata,
    input  logic              timer_irq
);

    typedef enum logic [3:0] {
        IDLE, WR_PL, WR_PH, WR_START, RUN, CLR, GUARD,
        SNAP_WR, SNAP_RL, SNAP_CL, SNAP_RH, SNAP_CH, WR_STOP, WR_CLR2
    } state_t;

    state_t            state_q, state_d;
    logic [31:0]       period_q, period_d;
    logic [TICK_W-1:0] tick_cnt_q, tick_cnt_d;
    logic              running_q, running_d;
    logic              stop_pend_q, stop_pend_d;
    logic              snap_pend_q, snap_pend_d;
    logic [15:0]       snap_lo_q, snap_lo_d;
    logic [31:0]       snap_value_q, snap_value_d;
    logic              snap_valid_q, snap_valid_d;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            period_q     <= '0;
            tick_cnt_q   <= '0;
            running_q    <= 1'b0;
            stop_pend_q  <= 1'b0;
            snap_pend_q  <= 1'b0;
            snap_lo_q    <= '0;
            snap_value_q <= '0;
            snap_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            period_q     <= period_d;
            tick_cnt_q   <= tick_cnt_d;
            running_q    <= running_d;
            stop_pend_q  <= stop_pend_d;
            snap_pend_q  <= snap_pend_d;
            snap_lo_q    <= snap_lo_d;
            snap_value_q <= snap_value_d;
            snap_valid_q <= snap_valid_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        period_d       = period_q;
        tick_cnt_d     = tick_cnt_q;
        running_d      = running_q;
        stop_pend_d    = stop_pend_q;
        snap_pend_d    = snap_pend_q;
        snap_lo_d      = snap_lo_q;
        snap_value_d   = snap_value_q;
        snap_valid_d   = 1'b0;
        tick           = 1'b0;
        avm_address    = 3'd0;
        avm_chipselect = 1'b0;
        avm_write_n    = 1'b1;
        avm_writedata  = 16'h0000;

        case (state_q)
            IDLE: begin
                if (cfg_start) begin
                    period_d   = (cfg_period < 32'(MIN_PERIOD)) ? 32'(MIN_PERIOD) : cfg_period;
                    tick_cnt_d = '0;
                    state_d    = WR_PL;
                end
            end
            WR_PL: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd2; avm_writedata = period_q[15:0];
                state_d = WR_PH;
            end
            WR_PH: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd3; avm_writedata = period_q[31:16];
                state_d = WR_START;
            end
            WR_START: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1; avm_writedata = 16'h0007;
                running_d = 1'b1;
                state_d   = RUN;
            end
            RUN: begin
                // IRQ outranks stop so a final timeout is still counted.
                if (timer_irq)        state_d = CLR;
                else if (stop_pend_q) begin state_d = WR_STOP; running_d = 1'b0; end
                else if (snap_pend_q) state_d = SNAP_WR;
            end
            CLR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd0;
                tick       = 1'b1;
                tick_cnt_d = tick_cnt_q + 1'b1;
                state_d    = GUARD;
            end
            GUARD: state_d = RUN;
            SNAP_WR: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd4;
                state_d = SNAP_RL;
            end
            SNAP_RL: begin
                avm_chipselect = 1'b1; avm_address = 3'd4;
                state_d = SNAP_CL;
            end
            SNAP_CL: begin
                snap_lo_d = avm_readdata;
                state_d   = SNAP_RH;
            end
            SNAP_RH: begin
                avm_chipselect = 1'b1; avm_address = 3'd5;
                state_d = SNAP_CH;
            end
            SNAP_CH: begin
                snap_value_d = {avm_readdata, snap_lo_q};
                snap_valid_d = 1'b1;
                snap_pend_d  = 1'b0;
                state_d      = RUN;
            end
            WR_STOP: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd1; avm_writedata = 16'h0008;
                state_d = WR_CLR2;
            end
            WR_CLR2: begin
                avm_chipselect = 1'b1; avm_write_n = 1'b0;
                avm_address = 3'd0;
                stop_pend_d = 1'b0;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Requests landing on the consuming cycle re-arm the flag after its clear.
        if (state_q != IDLE) begin
            if (cfg_stop) stop_pend_d = 1'b1;
            if (snap_req) snap_pend_d = 1'b1;
        end
    end

    assign busy       = (state_q != IDLE);
    assign running    = running_q;
    assign tick_count = tick_cnt_q;
    assign snap_value = snap_value_q;
    assign snap_valid = snap_valid_q;

endmodule

// File: tb/tb_de270_timer_driver.sv
// Directed/random bench for de270_timer_driver with a behavioural DE270 timer slave
// and queue-based logs of bus traffic, ticks and snapshots.
module tb_de270_timer_driver;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [31:0] cfg_period = '0;
    logic        cfg_start = 1'b0, cfg_stop = 1'b0, snap_req = 1'b0;
    logic        busy, running, tick, snap_valid;
    logic [15:0] tick_count;
    logic [31:0] snap_value;
    logic [2:0]  avm_address;
    logic        avm_chipselect, avm_write_n;
    logic [15:0] avm_writedata, avm_readdata;
    logic        timer_irq, force_irq = 1'b0;

    int n_asrt = 0, n_fail = 0, cyc = 0, n_snap = 0;
    logic [18:0] wr_ad[$];
    int          wr_cyc[$];
    logic [2:0]  rd_a[$];
    int          tick_cyc[$];

    de270_timer_driver #(.MIN_PERIOD(16), .TICK_W(16)) dut (
        .clk(clk), .reset_n(reset_n), .cfg_period(cfg_period), .cfg_start(cfg_start),
        .cfg_stop(cfg_stop), .snap_req(snap_req), .busy(busy), .running(running),
        .tick(tick), .tick_count(tick_count), .snap_value(snap_value), .snap_valid(snap_valid),
        .avm_address(avm_address), .avm_chipselect(avm_chipselect), .avm_write_n(avm_write_n),
        .avm_writedata(avm_writedata), .avm_readdata(avm_readdata), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Behavioural timer slave: counts period..0, timeout every period+1 cycles.
    logic [15:0] t_pl, t_ph, t_rd;
    logic [31:0] t_cnt, t_snap;
    logic        t_ito, t_cont, t_run, t_to;
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            t_pl <= '0; t_ph <= '0; t_rd <= '0; t_cnt <= '0; t_snap <= '0;
            t_ito <= 0; t_cont <= 0; t_run <= 0; t_to <= 0;
        end else begin
            if (t_run) begin
                if (t_cnt == 0) begin
                    t_to <= 1'b1; t_cnt <= {t_ph, t_pl};
                    if (!t_cont) t_run <= 1'b0;
                end else t_cnt <= t_cnt - 1;
            end
            if (avm_chipselect && avm_write_n)
                t_rd <= (avm_address == 3'd4) ? t_snap[15:0] :
                        (avm_address == 3'd5) ? t_snap[31:16] : 16'h0;
            if (avm_chipselect && !avm_write_n) begin
                case (avm_address)
                    3'd0: t_to <= 1'b0;
                    3'd1: begin
                        t_ito <= avm_writedata[0]; t_cont <= avm_writedata[1];
                        if (avm_writedata[2]) begin t_run <= 1'b1; t_cnt <= {t_ph, t_pl}; end
                        if (avm_writedata[3]) t_run <= 1'b0;
                    end
                    3'd2: t_pl <= avm_writedata;
                    3'd3: t_ph <= avm_writedata;
                    3'd4: t_snap <= t_cnt;
                    default: ;
                endcase
            end
        end
    end
    assign avm_readdata = t_rd;
    assign timer_irq    = (t_to & t_ito) | force_irq;

    always @(negedge clk) begin
        if (reset_n) begin
            if (avm_chipselect && !avm_write_n) begin
                wr_ad.push_back({avm_address, avm_writedata}); wr_cyc.push_back(cyc);
            end
            if (avm_chipselect && avm_write_n) rd_a.push_back(avm_address);
            if (tick) tick_cyc.push_back(cyc);
            if (snap_valid) n_snap++;
        end
    end

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_asrt++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [95:0] out_vec();
        return {busy, running, tick, tick_count, snap_value, snap_valid,
                avm_address, avm_chipselect, avm_write_n, avm_writedata};
    endfunction
    localparam logic [95:0] RESET_VEC = {23'd0, 1'b1, 16'h0};

    function automatic logic [18:0] wr_at(input int i);
        return (i < wr_ad.size()) ? wr_ad[i] : 19'h7ffff;
    endfunction

    task automatic clear_logs();
        @(posedge clk);
        wr_ad.delete(); wr_cyc.delete(); rd_a.delete(); tick_cyc.delete();
    endtask

    task automatic do_start(input logic [31:0] p, input string tag);
        logic [31:0] ep;
        ep = (p < 32'd16) ? 32'd16 : p;
        clear_logs();
        @(negedge clk); cfg_period = p; cfg_start = 1'b1;
        @(negedge clk); cfg_start = 1'b0;
        repeat (3) @(negedge clk);
        chk({tag, "_wr_seq"}, {wr_at(0), wr_at(1), wr_at(2)},
            {3'd2, ep[15:0], 3'd3, ep[31:16], 3'd1, 16'h0007});
        chk({tag, "_wr_consec"}, {32'(wr_cyc.size() >= 3 ? wr_cyc[2] - wr_cyc[0] : -1)}, 96'd2);
        chk({tag, "_running"}, {running, tick_count}, {1'b1, 16'd0});
    endtask

    task automatic wait_ticks(input int n, input int budget, input string tag);
        int k = 0;
        while (tick_cyc.size() < n && k < budget) begin @(negedge clk); k++; end
        chk({tag, "_ticks_seen"}, 96'(tick_cyc.size() >= n), 96'd1);
    endtask

    task automatic check_intervals(input int p, input string tag);
        int bad = 0;
        for (int i = 1; i < tick_cyc.size(); i++)
            if (tick_cyc[i] - tick_cyc[i-1] != p + 1) bad++;
        chk({tag, "_interval_errs"}, 96'(bad), 96'd0);
        @(negedge clk);
        chk({tag, "_tick_count"}, 96'(tick_count), 96'(16'(tick_cyc.size())));
    endtask

    task automatic do_stop(input string tag);
        int k = 0, n;
        clear_logs();
        @(negedge clk); cfg_stop = 1'b1;
        @(negedge clk); cfg_stop = 1'b0;
        while (busy && k < 60) begin @(negedge clk); k++; end
        n = wr_ad.size();
        chk({tag, "_stop_seq"}, {wr_at(n-2), wr_at(n-1)}, {3'd1, 16'h0008, 3'd0, 16'h0000});
        chk({tag, "_stopped"}, {busy, running}, 96'd0);
    endtask

    initial begin
        logic [31:0] p;
        int k, tc0, sn0, s_cyc, w_cyc, exp_cnt, diff;

        repeat (3) @(negedge clk);
        chk("reset_outputs", out_vec(), RESET_VEC);
        reset_n = 1'b1;
        @(negedge clk);
        chk("idle_outputs", out_vec(), RESET_VEC);

        // Plain runs: the documented period, then random periods at or above the floor.
        for (int it = 0; it < 4; it++) begin
            p = (it == 0) ? 32'h63 : 32'($urandom_range(16, 80));
            do_start(p, "run");
            wait_ticks(5, 1000, "run");
            check_intervals(int'(p), "run");
            do_stop("run");
        end

        // Below-floor periods clamp to 16, giving 17-cycle ticks.
        p = 32'($urandom_range(0, 15));
        do_start(p, "clamp");
        wait_ticks(50, 2000, "clamp");
        check_intervals(16, "clamp");
        do_stop("clamp");

        // Snapshot against a long period.
        p = 32'h0001_86A0;
        do_start(p, "snap");
        s_cyc = wr_cyc[2];
        repeat ($urandom_range(200, 500)) @(negedge clk);
        clear_logs();
        sn0 = n_snap;
        @(negedge clk); snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        k = 0;
        while (n_snap == sn0 && k < 20) begin @(negedge clk); k++; end
        repeat (2) @(negedge clk);
        chk("snap_valid_once", 96'(n_snap - sn0), 96'd1);
        chk("snap_bus_seq", {wr_at(0), 32'(wr_ad.size()), 32'(rd_a.size()),
                             (rd_a.size() == 2) ? {rd_a[0], rd_a[1]} : 6'h3f},
            {3'd4, 16'h0, 32'd1, 32'd2, 3'd4, 3'd5});
        chk("snap_le_period", 96'(snap_value <= p), 96'd1);
        w_cyc = (wr_cyc.size() > 0) ? wr_cyc[0] : 0;
        exp_cnt = int'(p) - (w_cyc - s_cyc - 1);
        diff = int'(snap_value) - exp_cnt;
        chk("snap_near_model", 96'(diff >= -6 && diff <= 6), 96'd1);

        // IRQ and stop in the same cycle: service the tick, then stop.
        repeat ($urandom_range(3, 20)) @(negedge clk);
        clear_logs();
        tc0 = int'(tick_count);
        @(negedge clk); force_irq = 1'b1; cfg_stop = 1'b1;
        @(negedge clk); force_irq = 1'b0; cfg_stop = 1'b0;
        k = 0;
        while (busy && k < 20) begin @(negedge clk); k++; end
        chk("irqstop_seq", {wr_at(0), wr_at(1), wr_at(2), 32'(wr_ad.size())},
            {3'd0, 16'h0, 3'd1, 16'h0008, 3'd0, 16'h0, 32'd3});
        chk("irqstop_tick", 96'(int'(tick_count) - tc0), 96'd1);
        chk("irqstop_idle_lat", 96'(wr_ad.size() == 3 ? cyc - wr_cyc[1] : -1), 96'd2);
        chk("irqstop_running", {busy, running}, 96'd0);

        // Snapshot requested during CLR and again during GUARD merges into one.
        do_start(32'($urandom_range(0, 15)), "merge");
        k = 0;
        while (!tick && k < 100) begin @(negedge clk); k++; end
        chk("merge_saw_tick", 96'(tick), 96'd1);
        rd_a.delete();
        sn0 = n_snap;
        snap_req = 1'b1;
        @(negedge clk);
        @(negedge clk); snap_req = 1'b0;
        repeat (40) @(negedge clk);
        chk("merge_one_snap", {32'(n_snap - sn0), 32'(rd_a.size())}, {32'd1, 32'd2});

        // Reset in the middle of the high-half read.
        @(negedge clk); snap_req = 1'b1;
        @(negedge clk); snap_req = 1'b0;
        k = 0;
        while (!(avm_chipselect && avm_write_n && avm_address == 3'd5) && k < 60) begin
            @(negedge clk); k++;
        end
        chk("rst_reached_rh", 96'(avm_address == 3'd5 && avm_chipselect), 96'd1);
        reset_n = 1'b0;
        #1;
        chk("rst_async_outputs", out_vec(), RESET_VEC);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        do_start(32'h63, "restart");
        wait_ticks(1, 200, "restart");
        @(negedge clk);
        chk("restart_first_tick", 96'(tick_count), 96'd1);
        do_stop("restart");

        $display("End of test - %0d assertions evaluated, %0d failures", n_asrt, n_fail);
        $finish;
    end

endmodule
